fetch_queue: RTL and testbench

Two-wide instruction fetch front end for the Tomasulo out-of-order core. It owns the fetch PC, drives both read ports of the dual-port instruction memory, and captures the returned instruction pairs into a circular queue. It presents up to two in-order instructions per cycle to the dispatch/issue stage, and flushes on a redirect from branch resolution.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_queue_if.sv | 20 ++
 rtl/fetch_ring.sv | 48 ++++
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the two-wide fetch front end.
package fetch_pkg;
    localparam int FQ_DEPTH    = 8;
    localparam int IMEM_ADDR_W = 4;

    typedef struct packed {
        logic [31:0]            instr;
        logic [IMEM_ADDR_W-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: IMEM read ports, redirect input and the dispatch-side output slots.
interface fetch_queue_if #(parameter int ADDR_W = 4);
    logic [ADDR_W-1:0] imem_addr0, imem_addr1;
    logic [31:0]       imem_data0, imem_data1;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [1:0]        out_valid;
    logic [31:0]       out_instr0, out_instr1;
    logic [ADDR_W-1:0] out_pc0, out_pc1;
    logic [1:0]        deq_ready;

    modport master (
        output imem_addr0, imem_addr1, out_valid, out_instr0, out_instr1, out_pc0, out_pc1,
        input  imem_data0, imem_data1, redirect_valid, redirect_pc, deq_ready
    );
    modport slave (
        input  imem_addr0, imem_addr1, out_valid, out_instr0, out_instr1, out_pc0, out_pc1,
        output imem_data0, imem_data1, redirect_valid, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_ring.sv
// Circular buffer of fetch entries: 2-wide enqueue, 0..2 dequeue from head, synchronous flush.
module fetch_ring
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq,
    input  fetch_entry_t             enq_e0,
    input  fetch_entry_t             enq_e1,
    input  logic [1:0]               deq_n,
    output fetch_entry_t             head_e0,
    output fetch_entry_t             head_e1,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   head, tail;

    // Reset seeds each entry's pc with its index so the idle outputs read pc 0 / pc 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '{instr: '0, pc: IMEM_ADDR_W'(i)};
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                mem[tail]         <= enq_e0;
                mem[tail + PW'(1)] <= enq_e1;
                tail              <= tail + PW'(2);
            end
            head  <= head + PW'(deq_n);
            count <= count + (enq ? (PW+1)'(2) : (PW+1)'(0)) - (PW+1)'(deq_n);
        end
    end

    assign head_e0 = mem[head];
    assign head_e1 = mem[head + PW'(1)];
endmodule

// File: rtl/fetch_queue.sv
// Two-wide fetch front end: PC, IMEM request tracking and the instruction queue.
// Optional FETCHQ_STALL_CNT_EN adds a saturating stall_cnt output.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    fetch_queue_if.master     fq
`ifdef FETCHQ_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc, pc_req;
    logic              req_pending, issue, enq, take0, take1;
    logic [1:0]        deq_n;
    logic [CW-1:0]     count;
    int                used;
    fetch_entry_t      e0, e1, h0, h1;

    // In-flight pair reserves two slots; dequeues this cycle are not credited.
    assign used  = int'(count) + (req_pending ? 2 : 0);
    assign issue = !fq.redirect_valid && (used <= DEPTH - 2);
    assign enq   = req_pending && !fq.redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            pc_req      <= '0;
            req_pending <= 1'b0;
        end else if (fq.redirect_valid) begin
            pc          <= fq.redirect_pc;
            req_pending <= 1'b0;
        end else begin
            req_pending <= issue;
            if (issue) begin
                pc     <= pc + ADDR_W'(2);
                pc_req <= pc;
            end
        end
    end

    assign take0 = fq.out_valid[0] && fq.deq_ready[0];
    assign take1 = take0 && fq.out_valid[1] && fq.deq_ready[1];
    assign deq_n = {1'b0, take0} + {1'b0, take1};

    assign e0 = '{instr: fq.imem_data0, pc: pc_req};
    assign e1 = '{instr: fq.imem_data1, pc: pc_req + ADDR_W'(1)};

    fetch_ring #(.DEPTH(DEPTH)) u_ring (
        .clk     (clk),
        .reset   (reset),
        .flush   (fq.redirect_valid),
        .enq     (enq),
        .enq_e0  (e0),
        .enq_e1  (e1),
        .deq_n   (deq_n),
        .head_e0 (h0),
        .head_e1 (h1),
        .count   (count)
    );

    assign fq.imem_addr0 = pc;
    assign fq.imem_addr1 = pc + ADDR_W'(1);
    assign fq.out_valid  = {count >= CW'(2), count >= CW'(1)};
    assign fq.out_instr0 = h0.instr;
    assign fq.out_instr1 = h1.instr;
    assign fq.out_pc0    = h0.pc;
    assign fq.out_pc1    = h1.pc;

`ifdef FETCHQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (!issue && !fq.redirect_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboarded bench for fetch_queue: IMEM word k holds 0x1000+k, consumer taken slots are popped and compared.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(4)) bus ();
`ifdef FETCHQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fetch_queue #(.DEPTH(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (bus)
`ifdef FETCHQ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Registered-read instruction memory.
    always @(posedge clk) begin
        bus.imem_data0 <= 32'h1000 + 32'(bus.imem_addr0);
        bus.imem_data1 <= 32'h1000 + 32'(bus.imem_addr1);
    end

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q [$];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input int start, input int n);
        logic [3:0] p;
        for (int i = 0; i < n; i++) begin
            p = 4'(start + i);
            exp_q.push_back({32'h1000 + 32'(p), p});
        end
    endtask

    task automatic pop_cmp(input string name, input logic [31:0] instr, input logic [3:0] pc);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h/%h expected nothing (scoreboard empty)", name, instr, pc);
        end else begin
            chk(name, {instr, pc}, exp_q.pop_front());
        end
    endtask

    // Monitor: every slot the consumer actually takes must match the next expected entry.
    always @(negedge clk) begin
        logic t0, t1;
        if (!reset && !bus.redirect_valid) begin
            t0 = bus.out_valid[0] && bus.deq_ready[0];
            t1 = t0 && bus.out_valid[1] && bus.deq_ready[1];
            if (t0) pop_cmp("sb_slot0", bus.out_instr0, bus.out_pc0);
            if (t1) pop_cmp("sb_slot1", bus.out_instr1, bus.out_pc1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    logic [3:0]  hold_pc;
    logic [15:0] prev_sc;

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_ready      = 2'b00;
        reset              = 1'b1;
        repeat (3) tick();

        // Reset state
        neg();
        chk("rst_valid", 36'(bus.out_valid), 36'd0);
        chk("rst_instr0", 36'(bus.out_instr0), 36'd0);
        chk("rst_pc0", 36'(bus.out_pc0), 36'd0);
        chk("rst_pc1", 36'(bus.out_pc1), 36'd1);
        chk("rst_addr0", 36'(bus.imem_addr0), 36'd0);
        chk("rst_addr1", 36'(bus.imem_addr1), 36'd1);
`ifdef FETCHQ_STALL_CNT_EN
        chk("rst_stall", 36'(stall_cnt), 36'd0);
`endif

        // Free run from pc 0
        tick();
        reset = 1'b0;
        bus.deq_ready = 2'b11;
        push_seq(0, 200);
        tick(); neg();
        chk("first_valid_e0", 36'(bus.out_valid), 36'd0);
        tick(); neg();
        chk("first_valid_e1", 36'(bus.out_valid), 36'd3);
        chk("first_pair0", {bus.out_instr0, bus.out_pc0}, {32'h1000, 4'd0});
        chk("first_pair1", {bus.out_instr1, bus.out_pc1}, {32'h1001, 4'd1});
        for (int i = 0; i < 8; i++) begin
            tick(); neg();
            chk("steady_2wide", 36'(bus.out_valid), 36'd3);
        end

        // Consumer stalls: queue fills and fetch stops
        tick();
        bus.deq_ready = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        neg();
        hold_pc = bus.imem_addr0;
`ifdef FETCHQ_STALL_CNT_EN
        prev_sc = stall_cnt;
`endif
        for (int i = 0; i < 10; i++) begin
            tick(); neg();
            chk("full_valid", 36'(bus.out_valid), 36'd3);
            chk("full_pc_hold", 36'(bus.imem_addr0), 36'(hold_pc));
`ifdef FETCHQ_STALL_CNT_EN
            chk("stall_inc", 36'(stall_cnt), 36'(prev_sc + 16'd1));
            prev_sc = stall_cnt;
`endif
        end

        // Release; scoreboard checks order continues without duplicates
        tick();
        bus.deq_ready = 2'b11;
        repeat (8) tick();

        // One per cycle
        bus.deq_ready = 2'b01;
        for (int i = 0; i < 12; i++) begin
            tick(); neg();
            chk("single_valid0", 36'(bus.out_valid[0]), 36'd1);
        end

        // deq_ready[1] alone never dequeues
        tick();
        bus.deq_ready = 2'b10;
        repeat (4) tick();
        neg();
        hold_pc = bus.out_pc0;
        chk("slot1_only_valid", 36'(bus.out_valid), 36'd3);
        for (int i = 0; i < 3; i++) begin
            tick(); neg();
            chk("slot1_only_hold", 36'(bus.out_pc0), 36'(hold_pc));
        end

        // Redirect to 5 with a response in flight
        tick();
        bus.deq_ready = 2'b11;
        repeat (5) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 4'd5;
        exp_q.delete();
        push_seq(5, 200);
        tick();
        bus.redirect_valid = 1'b0;
        neg();
        chk("redir_valid_t1", 36'(bus.out_valid), 36'd0);
        tick(); neg();
        chk("redir_valid_t2", 36'(bus.out_valid), 36'd0);
        tick(); neg();
        chk("redir_valid_t3", 36'(bus.out_valid), 36'd3);
        chk("redir_pair0", {bus.out_instr0, bus.out_pc0}, {32'h1005, 4'd5});
        chk("redir_pair1", {bus.out_instr1, bus.out_pc1}, {32'h1006, 4'd6});
        repeat (6) tick();

        // PC wrap from 14
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 4'd14;
        exp_q.delete();
        push_seq(14, 200);
        tick();
        bus.redirect_valid = 1'b0;
        tick(); tick(); neg();
        chk("wrap_pair0", {bus.out_instr0, bus.out_pc0}, {32'h100e, 4'd14});
        chk("wrap_pair1", {bus.out_instr1, bus.out_pc1}, {32'h100f, 4'd15});
        tick(); neg();
        chk("wrap_pair2", {bus.out_instr0, bus.out_pc0}, {32'h1000, 4'd0});
        chk("wrap_pair3", {bus.out_instr1, bus.out_pc1}, {32'h1001, 4'd1});
        repeat (4) tick();

        // Reset mid-stream with a full queue
        bus.deq_ready = 2'b00;
        repeat (12) tick();
        neg();
        chk("pre_rst_full", 36'(bus.out_valid), 36'd3);
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        bus.deq_ready = 2'b11;
        push_seq(0, 200);
        neg();
        chk("midrst_valid", 36'(bus.out_valid), 36'd0);
        chk("midrst_addr0", 36'(bus.imem_addr0), 36'd0);
`ifdef FETCHQ_STALL_CNT_EN
        chk("midrst_stall", 36'(stall_cnt), 36'd0);
`endif
        tick(); tick(); neg();
        chk("midrst_pair0", {bus.out_instr0, bus.out_pc0}, {32'h1000, 4'd0});
        repeat (6) tick();

        bus.deq_ready = 2'b00;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
